display_scan_sequencer: RTL and testbench

Upstream driver for the CL341AH digit-enable decoder. It time-multiplexes a 16-bit hex value across the four digits of the display:
- generates the 2-bit digit select consumed by the decoder;
- inserts an anti-ghosting blank interval before each digit;
- produces the matching active-low segment and decimal-point drive.

New display values arrive over a valid/ready handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/display_scan_sequencer_if.sv | 22 ++
 rtl/display_scan_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_display_scan_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_sequencer_if.sv
// Load channel for display_scan_sequencer: a new 16-bit hex value and its
// decimal-point mask, transferred on load_valid && load_ready.
interface display_scan_sequencer_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic [3:0]  load_dp;

    modport master (
        output load_valid,
        output load_value,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  load_dp,
        output load_ready
    );
endinterface

// File: rtl/display_scan_sequencer.sv
// Four-digit multiplexed 7-segment scan driver with anti-ghost blanking and frame-aligned loads.
// Optional feature macro: LEADING_ZERO_SUPPRESS_EN (blank digits above the highest nonzero digit).
module display_scan_sequencer #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                           clk,
    input  logic                           rst_n,
    display_scan_sequencer_if.slave        load,
    output logic [1:0]                     select,
    output logic [6:0]                     seg_n,
    output logic                           dp_n,
    output logic                           frame_end
);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

`ifdef LEADING_ZERO_SUPPRESS_EN
    function automatic logic [1:0] top_digit(input logic [15:0] value);
        logic [1:0] idx;
        if (value[15:12] != 4'h0) begin
            idx = 2'd3;
        end else if (value[11:8] != 4'h0) begin
            idx = 2'd2;
        end else if (value[7:4] != 4'h0) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction
`endif

    state_t           state_r, state_nx_s;
    logic [1:0]       digit_r, digit_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic             frame_end_r, frame_end_nx_s;
    logic [6:0]       seg_n_r, seg_show_s;
    logic             dp_n_r;
    logic [3:0]       digit_hex_s;
    logic [15:0]      shadow_value_r, pending_value_r;
    logic [3:0]       shadow_dp_r, pending_dp_r;
    logic             pending_full_r;
    logic             take_s, commit_s;

    // Phase sequencing: blank, then dwell, then advance digit.
    always_comb begin
        state_nx_s = state_r;
        digit_nx_s = digit_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_BLANK: begin
                if (!HAS_BLANK || (cnt_r == BLANK_LAST)) begin
                    state_nx_s = ST_SHOW;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt_r == DWELL_LAST) begin
                    digit_nx_s = digit_r + 2'd1;
                    cnt_nx_s   = '0;
                    if (HAS_BLANK) begin
                        state_nx_s = ST_BLANK;
                    end else begin
                        state_nx_s = ST_SHOW;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_SHOW;
                digit_nx_s = 2'd0;
                cnt_nx_s   = '0;
            end
        endcase
        // Registered pulse: asserted while the FSM sits in digit 3's final dwell cycle.
        frame_end_nx_s = (state_nx_s == ST_SHOW) && (digit_nx_s == 2'd3) && (cnt_nx_s == DWELL_LAST);
    end

    // FSM state, digit index and phase counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (HAS_BLANK) begin
                state_r <= ST_BLANK;
            end else begin
                state_r <= ST_SHOW;
            end
            digit_r     <= 2'd0;
            cnt_r       <= '0;
            frame_end_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            digit_r     <= digit_nx_s;
            cnt_r       <= cnt_nx_s;
            frame_end_r <= frame_end_nx_s;
        end
    end

    // Segment pattern for the digit currently being shown.
    always_comb begin
        digit_hex_s = shadow_value_r[{digit_r, 2'b00} +: 4];
        seg_show_s  = 7'h7F;
`ifdef LEADING_ZERO_SUPPRESS_EN
        if (digit_r > top_digit(shadow_value_r)) begin
            seg_show_s = 7'h7F;
        end else begin
            seg_show_s = hex_to_seg_n(digit_hex_s);
        end
`else
        seg_show_s = hex_to_seg_n(digit_hex_s);
`endif
    end

    // Extra output stage so segments line up with the decoder's registered select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_n_r <= 7'h7F;
            dp_n_r  <= 1'b1;
        end else if (state_r == ST_SHOW) begin
            seg_n_r <= seg_show_s;
            dp_n_r  <= ~shadow_dp_r[digit_r];
        end else begin
            seg_n_r <= 7'h7F;
            dp_n_r  <= 1'b1;
        end
    end

    assign take_s   = load.load_valid && !pending_full_r;
    assign commit_s = frame_end_r && pending_full_r;

    // One-deep pending buffer; its contents move to the shadow only at frame end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_value_r  <= 16'h0000;
            shadow_dp_r     <= 4'h0;
            pending_value_r <= 16'h0000;
            pending_dp_r    <= 4'h0;
            pending_full_r  <= 1'b0;
        end else if (commit_s) begin
            shadow_value_r <= pending_value_r;
            shadow_dp_r    <= pending_dp_r;
            pending_full_r <= 1'b0;
        end else if (take_s) begin
            pending_value_r <= load.load_value;
            pending_dp_r    <= load.load_dp;
            pending_full_r  <= 1'b1;
        end else begin
            pending_full_r <= pending_full_r;
        end
    end

    assign load.load_ready = ~pending_full_r;
    assign select          = digit_r;
    assign seg_n           = seg_n_r;
    assign dp_n            = dp_n_r;
    assign frame_end       = frame_end_r;
endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed bench for display_scan_sequencer: one DUT with DWELL=4/BLANK=2, one with DWELL=1/BLANK=0.
module tb_display_scan_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] select1, select2;
    logic [6:0] seg1, seg2;
    logic       dp1, dp2, fe1, fe2;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic [15:0] fv [0:4];
    logic [3:0]  fd [0:4];

`ifdef LEADING_ZERO_SUPPRESS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    display_scan_sequencer_if bus1();
    display_scan_sequencer_if bus2();

    display_scan_sequencer #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(bus1.slave),
        .select(select1), .seg_n(seg1), .dp_n(dp1), .frame_end(fe1)
    );

    display_scan_sequencer #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(bus2.slave),
        .select(select2), .seg_n(seg2), .dp_n(dp2), .frame_end(fe2)
    );

    function automatic logic [6:0] hexseg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic int hi_digit(input logic [15:0] v);
        if (v[15:12] != 4'h0) return 3;
        if (v[11:8] != 4'h0) return 2;
        if (v[7:4] != 4'h0) return 1;
        return 0;
    endfunction

    // Expected dut1 outputs at cycle c (cycle 0 = first cycle after reset release).
    function automatic logic [1:0] e_sel1(input int c);
        return 2'((c / 6) % 4);
    endfunction

    function automatic logic e_fe1(input int c);
        return ((c % 24) == 23);
    endfunction

    function automatic logic [6:0] e_seg1(input int c);
        int p, d;
        logic [15:0] v;
        if (c == 0) return 7'h7F;
        p = c - 1;
        if ((p % 6) < 2) return 7'h7F;
        d = (p / 6) % 4;
        v = fv[p / 24];
        if (LZ && (d > hi_digit(v))) return 7'h7F;
        return hexseg(v[4*d +: 4]);
    endfunction

    function automatic logic e_dp1(input int c);
        int p, d;
        logic [3:0] m;
        if (c == 0) return 1'b1;
        p = c - 1;
        if ((p % 6) < 2) return 1'b1;
        d = (p / 6) % 4;
        m = fd[p / 24];
        return ~m[d];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.load_valid = 1'b0; bus1.load_value = 16'h0000; bus1.load_dp = 4'h0;
        bus2.load_valid = 1'b0; bus2.load_value = 16'h0000; bus2.load_dp = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (select1 !== 2'd0) begin errors++; $display("FAIL reset_sel1 got %0d exp 0", select1); end
        checks++; if (seg1 !== 7'h7F) begin errors++; $display("FAIL reset_seg1 got %h exp 7f", seg1); end
        checks++; if (dp1 !== 1'b1) begin errors++; $display("FAIL reset_dp1 got %b exp 1", dp1); end
        checks++; if (fe1 !== 1'b0) begin errors++; $display("FAIL reset_fe1 got %b exp 0", fe1); end
        checks++; if (bus1.load_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy1 got %b exp 1", bus1.load_ready); end
        checks++; if (select2 !== 2'd0) begin errors++; $display("FAIL reset_sel2 got %0d exp 0", select2); end
        checks++; if (seg2 !== 7'h7F) begin errors++; $display("FAIL reset_seg2 got %h exp 7f", seg2); end
        checks++; if (fe2 !== 1'b0) begin errors++; $display("FAIL reset_fe2 got %b exp 0", fe2); end
        checks++; if (bus2.load_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy2 got %b exp 1", bus2.load_ready); end
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // Frame 0 shows reset shadow; 12AF/0100 loaded mid-frame shows in frame 1.
    task automatic test_scan_and_load();
        logic exp_rdy;
        fv[0] = 16'h0000; fd[0] = 4'h0;
        fv[1] = 16'h12AF; fd[1] = 4'b0100;
        while (cyc <= 47) begin
            exp_rdy = (cyc <= 5) || (cyc >= 24);
            checks++; if (select1 !== e_sel1(cyc)) begin errors++; $display("FAIL scan_sel c=%0d got %0d exp %0d", cyc, select1, e_sel1(cyc)); end
            checks++; if (seg1 !== e_seg1(cyc)) begin errors++; $display("FAIL scan_seg c=%0d got %h exp %h", cyc, seg1, e_seg1(cyc)); end
            checks++; if (dp1 !== e_dp1(cyc)) begin errors++; $display("FAIL scan_dp c=%0d got %b exp %b", cyc, dp1, e_dp1(cyc)); end
            checks++; if (fe1 !== e_fe1(cyc)) begin errors++; $display("FAIL scan_fe c=%0d got %b exp %b", cyc, fe1, e_fe1(cyc)); end
            checks++; if (bus1.load_ready !== exp_rdy) begin errors++; $display("FAIL scan_rdy c=%0d got %b exp %b", cyc, bus1.load_ready, exp_rdy); end
            if (cyc == 5) begin
                bus1.load_valid = 1'b1; bus1.load_value = 16'h12AF; bus1.load_dp = 4'b0100;
            end else if (cyc == 6) begin
                bus1.load_valid = 1'b0;
            end
            step();
        end
    endtask

    // 1111 accepted, 2222 held against a full buffer until the frame after.
    task automatic test_back_to_back();
        logic exp_rdy;
        fv[2] = 16'h12AF; fd[2] = 4'b0100;
        fv[3] = 16'h1111; fd[3] = 4'h0;
        fv[4] = 16'h2222; fd[4] = 4'h0;
        while (cyc <= 110) begin
            exp_rdy = (cyc <= 50) || (cyc == 72) || ((cyc >= 96) && (cyc <= 100));
            checks++; if (select1 !== e_sel1(cyc)) begin errors++; $display("FAIL b2b_sel c=%0d got %0d exp %0d", cyc, select1, e_sel1(cyc)); end
            checks++; if (seg1 !== e_seg1(cyc)) begin errors++; $display("FAIL b2b_seg c=%0d got %h exp %h", cyc, seg1, e_seg1(cyc)); end
            checks++; if (dp1 !== e_dp1(cyc)) begin errors++; $display("FAIL b2b_dp c=%0d got %b exp %b", cyc, dp1, e_dp1(cyc)); end
            checks++; if (fe1 !== e_fe1(cyc)) begin errors++; $display("FAIL b2b_fe c=%0d got %b exp %b", cyc, fe1, e_fe1(cyc)); end
            checks++; if (bus1.load_ready !== exp_rdy) begin errors++; $display("FAIL b2b_rdy c=%0d got %b exp %b", cyc, bus1.load_ready, exp_rdy); end
            case (cyc)
                50:  begin bus1.load_valid = 1'b1; bus1.load_value = 16'h1111; bus1.load_dp = 4'h0; end
                51:  begin bus1.load_value = 16'h2222; end
                73:  begin bus1.load_valid = 1'b0; end
                100: begin bus1.load_valid = 1'b1; bus1.load_value = 16'h3333; end
                101: begin bus1.load_valid = 1'b0; end
                default: begin end
            endcase
            step();
        end
    endtask

    // One-cycle reset while digit 2 of 2222 is being shown, with 3333 pending.
    task automatic test_mid_reset();
        checks++; if (select1 !== 2'd2) begin errors++; $display("FAIL mid_pre_sel got %0d exp 2", select1); end
        checks++; if (seg1 !== 7'h24) begin errors++; $display("FAIL mid_pre_seg got %h exp 24", seg1); end
        rst_n = 1'b0;
        step();
        checks++; if (select1 !== 2'd0) begin errors++; $display("FAIL mid_sel got %0d exp 0", select1); end
        checks++; if (seg1 !== 7'h7F) begin errors++; $display("FAIL mid_seg got %h exp 7f", seg1); end
        checks++; if (dp1 !== 1'b1) begin errors++; $display("FAIL mid_dp got %b exp 1", dp1); end
        checks++; if (fe1 !== 1'b0) begin errors++; $display("FAIL mid_fe got %b exp 0", fe1); end
        checks++; if (bus1.load_ready !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b exp 1", bus1.load_ready); end
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // DWELL=1, BLANK=0: one digit per clock, no blank, frame_end every 4.
    task automatic test_no_blank();
        logic [6:0] es;
        while (cyc <= 11) begin
            if (cyc == 0) es = 7'h7F;
            else if (LZ && (((cyc - 1) % 4) > 0)) es = 7'h7F;
            else es = 7'h40;
            checks++; if (select2 !== 2'(cyc % 4)) begin errors++; $display("FAIL nb_sel c=%0d got %0d exp %0d", cyc, select2, cyc % 4); end
            checks++; if (fe2 !== ((cyc % 4) == 3)) begin errors++; $display("FAIL nb_fe c=%0d got %b", cyc, fe2); end
            checks++; if (seg2 !== es) begin errors++; $display("FAIL nb_seg c=%0d got %h exp %h", cyc, seg2, es); end
            checks++; if (dp2 !== 1'b1) begin errors++; $display("FAIL nb_dp c=%0d got %b exp 1", cyc, dp2); end
            checks++; if (bus1.load_ready !== 1'b1) begin errors++; $display("FAIL nb_rdy1 c=%0d got %b exp 1", cyc, bus1.load_ready); end
            checks++; if (select1 !== e_sel1(cyc)) begin errors++; $display("FAIL nb_sel1 c=%0d got %0d exp %0d", cyc, select1, e_sel1(cyc)); end
            step();
        end
    endtask

    // Shadow cleared by reset, then 0050 shown (leading zeros per build option).
    task automatic test_leading_zero();
        logic exp_rdy;
        fv[0] = 16'h0000; fd[0] = 4'h0;
        fv[1] = 16'h0050; fd[1] = 4'h0;
        while (cyc <= 47) begin
            exp_rdy = (cyc <= 12) || (cyc >= 24);
            checks++; if (seg1 !== e_seg1(cyc)) begin errors++; $display("FAIL lz_seg c=%0d got %h exp %h", cyc, seg1, e_seg1(cyc)); end
            checks++; if (dp1 !== e_dp1(cyc)) begin errors++; $display("FAIL lz_dp c=%0d got %b exp %b", cyc, dp1, e_dp1(cyc)); end
            checks++; if (fe1 !== e_fe1(cyc)) begin errors++; $display("FAIL lz_fe c=%0d got %b exp %b", cyc, fe1, e_fe1(cyc)); end
            checks++; if (bus1.load_ready !== exp_rdy) begin errors++; $display("FAIL lz_rdy c=%0d got %b exp %b", cyc, bus1.load_ready, exp_rdy); end
            if (cyc == 12) begin
                bus1.load_valid = 1'b1; bus1.load_value = 16'h0050; bus1.load_dp = 4'h0;
            end else if (cyc == 13) begin
                bus1.load_valid = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_scan_and_load();
        test_back_to_back();
        test_mid_reset();
        test_no_blank();
        test_leading_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
